// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit datapath: opcodes, instruction field
// positions, address width and the fetch FSM encoding.
package cpu16_pkg;

  localparam int PC_W = 16;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 8;
  localparam int RS_HI   = 7;
  localparam int RS_LO   = 4;
  localparam int IMM4_HI = 3;
  localparam int IMM4_LO = 0;

  typedef enum logic [0:0] {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory fetch bus; the fetch stage is the master, memory the slave.
interface fetch_decode_stage_if;
  import cpu16_pkg::*;

  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic [15:0]     imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/fetch_decode_stage_if_id_reg.sv
// IF/ID pipeline register: flush clears only the valid bit, so the payload
// keeps its last value for the downstream field slices.
module if_id_reg
  import cpu16_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            load_i,
  input  logic            drain_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [15:0]     instr_i,
  output logic            valid_o,
  output logic [PC_W-1:0] pc_o,
  output logic [15:0]     instr_o
);

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_decode_stage.sv
// Instruction fetch and IF/ID stage: PC, FETCH/HALTED control, the
// delivered-instruction counter and the decoded field slices.
module fetch_decode_stage
  import cpu16_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_W     = cpu16_pkg::PC_W
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_stage_if.master  imem,
  input  logic                  redirect_valid,
  input  logic [PC_W-1:0]       redirect_pc,
  input  logic                  id_stall,
  output logic                  id_valid,
  output logic [PC_W-1:0]       id_pc,
  output logic [15:0]           id_instr,
  output logic [3:0]            id_opcode,
  output logic [3:0]            id_rd,
  output logic [3:0]            id_rs,
  output logic [3:0]            id_imm4,
  output logic                  halted,
  output logic [15:0]           instr_count
);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     count_q, count_d;
  logic            accept, fetch_done, consume;

  // Requests are purely combinational, so nothing is ever left in flight.
  assign accept        = !id_valid || !id_stall;
  assign imem.imem_req = !reset && (state_q == FETCH) && accept && !redirect_valid;
  assign imem.imem_addr = pc_q;
  assign fetch_done    = imem.imem_req && imem.imem_ready;
  assign consume       = id_valid && !id_stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (consume && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
    if (redirect_valid) begin
      state_d = FETCH;
      pc_d    = redirect_pc;
    end else if (fetch_done) begin
      pc_d = pc_q + 1'b1;
      if (imem.imem_rdata[OPC_HI:OPC_LO] == OP_HALT) begin
        state_d = HALTED;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC[PC_W-1:0];
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .load_i  (fetch_done),
    .drain_i (consume),
    .pc_i    (pc_q),
    .instr_i (imem.imem_rdata),
    .valid_o (id_valid),
    .pc_o    (id_pc),
    .instr_o (id_instr)
  );

  assign id_opcode   = id_instr[OPC_HI:OPC_LO];
  assign id_rd       = id_instr[RD_HI:RD_LO];
  assign id_rs       = id_instr[RS_HI:RS_LO];
  assign id_imm4     = id_instr[IMM4_HI:IMM4_LO];
  assign halted      = (state_q == HALTED);
  assign instr_count = count_q;

endmodule

// File: doc/fetch_decode_stage.md
# fetch_decode_stage

Instruction fetch and IF/ID pipeline stage for the 16-bit datapath. Holds the program counter and fetches one 16-bit instruction per cycle from instruction memory over a ready handshake. Registers the instruction into IF/ID and splits out opcode, register and 4-bit immediate fields. The immediate field (`id_imm4`) feeds the 4-to-16 zero-extension stage directly downstream.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `PC_W`, 16, PC and address width. Fixed at 16 for this datapath.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  16  word address; always equals PC.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; only meaningful while `imem_req`=1.
- `imem_rdata`  in  16  instruction word.
- `redirect_valid`  in  1  branch/jump redirect.
- `redirect_pc`  in  16  redirect target.
- `id_stall`  in  1  downstream cannot accept the IF/ID contents this cycle.
- `id_valid`  out  1  IF/ID holds a valid instruction.
- `id_pc`  out  16  PC of the IF/ID instruction.
- `id_instr`  out  16  raw instruction.
- `id_opcode`  out  4  bits [15:12].
- `id_rd`  out  4  bits [11:8].
- `id_rs`  out  4  bits [7:4].
- `id_imm4`  out  4  bits [3:0]; goes to the zero-extender.
- `halted`  out  1  stage is in HALTED.
- `instr_count`  out  16  instructions delivered downstream; saturating.

## Operation
- FSM states: FETCH and HALTED.
- Accept condition: `accept = !id_valid || !id_stall`.
- `imem_req = (state==FETCH) && accept && !redirect_valid`. This is combinational, so no request is ever outstanding across cycles.
- Fetch completes when `imem_req && imem_ready`. At that edge:
  - IF/ID loads `imem_rdata` with `id_pc <= pc`.
  - `id_valid <= 1`.
  - `pc <= pc + 1`, modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- Consumption: the downstream stage takes the instruction on any cycle with `id_valid && !id_stall`. If no fetch completes in that same cycle, `id_valid <= 0`.
- Stall: while `id_valid && id_stall`, IF/ID and PC hold and `imem_req`=0.
- Redirect has the highest priority after reset:
  - `pc <= redirect_pc`, `id_valid <= 0`, state goes to FETCH.
  - Any `imem_ready`/`imem_rdata` in that cycle is ignored.
- HALT: when a fetch completes with opcode 4'hF, the word is delivered normally and the state goes to HALTED. `pc` still advances.
  - HALTED issues no requests.
  - HALTED exits only on `redirect_valid` (to FETCH) or `reset`.
- `instr_count` increments on each consumption and saturates at 16'hFFFF.
- Field outputs are combinational slices of the `id_instr` register. They hold their last value while `id_valid`=0.

## Timing
- Reset values (synchronous, next edge):
  - `pc` = `RESET_PC`, state = FETCH.
  - `id_valid` = 0; `id_instr`, `id_pc` and all fields = 0.
  - `instr_count` = 0, `halted` = 0.
  - `imem_req` = 0 during any cycle with `reset`=1.
- Reset asserted mid-stall or mid-HALT: reset wins over everything, including redirect.
- Latency: `imem_ready` in cycle N gives `id_valid`=1 and fields valid in cycle N+1.
- Throughput: one instruction per cycle while `imem_ready`=1 and `id_stall`=0.
- Consumption and a new fetch in the same cycle: IF/ID is replaced and `id_valid` stays 1. There is no bubble.
- Redirect and consumption in the same cycle: the consumed instruction still counts in `instr_count`, and IF/ID is then flushed.
- `imem_ready` while `imem_req`=0 is ignored.

## Structure
- Shared package `cpu16_pkg`:
  - opcode constants, including `OP_HALT = 4'hF`;
  - field bit positions (OPC_HI/LO, RD, RS, IMM4);
  - `PC_W = 16` and the FETCH/HALTED state encoding.
- One sub-module, `if_id_reg`: the IF/ID register with load/flush/hold controls, holding `id_valid`, `id_pc` and `id_instr`. The PC, FSM and counter stay in the top module.

## Test plan
- Reset then `imem_ready`=1 every cycle, words 16'h1234, 16'h2349, 16'h3452, `id_stall`=0 -> `imem_addr` 0,1,2:
  - `id_valid` rises one cycle after the first ready;
  - first word gives `id_opcode`=1, `id_rd`=2, `id_rs`=3, `id_imm4`=4, `id_pc`=0;
  - `instr_count` increments each cycle.
- `id_stall`=1 for 3 cycles while `id_valid`=1 -> `imem_req`=0 and IF/ID/PC hold; on release the next fetch resumes at the held PC with no lost or duplicated word.
- `redirect_valid`=1 with `redirect_pc`=16'h0040, with `imem_ready`=1 in the same cycle -> `id_valid`=0 next cycle, that cycle's data is discarded, and the next `imem_addr`=16'h0040.
- PC at 16'hFFFF with a fetch completing -> `id_pc`=16'hFFFF and the next `imem_addr`=16'h0000.
- Fetch of 16'hF000 -> delivered with `id_opcode`=4'hF, then `halted`=1 and `imem_req` stays 0 for 10 cycles; a redirect to 16'h0010 resumes fetch and clears `halted`.
- `reset` asserted during a stall with `id_valid`=1 -> next cycle `id_valid`=0, `instr_count`=0, `imem_addr`=`RESET_PC`.
